// File: rtl/nesapu_vgm_pkg.sv
// Shared opcode constants, wait lengths and FSM state encoding for the
// VGM command sequencer that feeds the nesapu register-write port.
package nesapu_vgm_pkg;

    localparam logic [7:0] OP_APU_WR          = 8'hB4;
    localparam logic [7:0] OP_WAIT_N          = 8'h61;
    localparam logic [7:0] OP_WAIT_735        = 8'h62;
    localparam logic [7:0] OP_WAIT_882        = 8'h63;
    localparam logic [7:0] OP_END             = 8'h66;
    localparam logic [7:0] OP_WAIT_SHORT      = 8'h70;
    localparam logic [7:0] OP_WAIT_SHORT_MASK = 8'hF0;

    localparam logic [15:0] WAIT_NTSC_FRAME = 16'd735;
    localparam logic [15:0] WAIT_PAL_FRAME  = 16'd882;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_ARG,
        ST_WRITE,
        ST_GAP,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } seq_state_t;

endpackage

// File: rtl/nesapu_sample_timer.sv
// Sample-rate wait timer: an 8-bit clock divider feeding a 16-bit sample
// down-counter; expire fires in the final clock of the final sample.
module nesapu_sample_timer #(
    parameter int CLK_PER_SAMPLE = 41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] n,
    output logic        expire
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLK_PER_SAMPLE - 1);

    logic [7:0]  div_q, div_d;
    logic [15:0] cnt_q, cnt_d;

    assign expire = (cnt_q == 16'd1) && (div_q == 8'd0);

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            div_d = DIV_RELOAD;
            cnt_d = n;
        end else if (cnt_q != 16'd0) begin
            if (div_q == 8'd0) begin
                div_d = DIV_RELOAD;
                cnt_d = cnt_q - 16'd1;
            end else begin
                div_d = div_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 8'd0;
            cnt_q <= 16'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nesapu_vgm_seq.sv
// VGM command sequencer: decodes a valid/ready byte stream into nesapu
// register write strobes and sample-accurate waits.
module nesapu_vgm_seq
    import nesapu_vgm_pkg::*;
#(
    parameter int CLK_PER_SAMPLE = 41
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_ready,
    input  logic       in_restart,
    output logic [4:0] out_reg,
    output logic [7:0] out_val,
    output logic       out_wr,
    output logic       out_busy,
    output logic       out_done,
    output logic       out_err
);

    seq_state_t  state_q, state_d;
    logic        arg_sel_q, arg_sel_d;
    logic        is_apu_q, is_apu_d;
    logic [7:0]  arg_lo_q, arg_lo_d;
    logic [4:0]  reg_q, reg_d;
    logic [7:0]  val_q, val_d;
    logic        wr_q, busy_q, done_q, err_q;
    logic        wr_d, busy_d, done_d, err_d;
    logic        accept;
    logic        tmr_load;
    logic [15:0] tmr_n;
    logic        tmr_expire;

    assign out_ready = (state_q == ST_FETCH) || (state_q == ST_ARG);
    assign accept    = in_valid && out_ready;

    nesapu_sample_timer #(
        .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
    ) u_timer (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .load  (tmr_load),
        .n     (tmr_n),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        arg_sel_d = arg_sel_q;
        is_apu_d  = is_apu_q;
        arg_lo_d  = arg_lo_q;
        reg_d     = reg_q;
        val_d     = val_q;
        tmr_load  = 1'b0;
        tmr_n     = 16'd0;
        unique case (state_q)
            ST_FETCH: if (accept) begin
                arg_sel_d = 1'b0;
                if (in_data == OP_APU_WR) begin
                    is_apu_d = 1'b1;
                    state_d  = ST_ARG;
                end else if (in_data == OP_WAIT_N) begin
                    is_apu_d = 1'b0;
                    state_d  = ST_ARG;
                end else if (in_data == OP_WAIT_735) begin
                    tmr_load = 1'b1;
                    tmr_n    = WAIT_NTSC_FRAME;
                    state_d  = ST_WAIT;
                end else if (in_data == OP_WAIT_882) begin
                    tmr_load = 1'b1;
                    tmr_n    = WAIT_PAL_FRAME;
                    state_d  = ST_WAIT;
                end else if ((in_data & OP_WAIT_SHORT_MASK) == OP_WAIT_SHORT) begin
                    tmr_load = 1'b1;
                    tmr_n    = 16'(in_data[3:0]) + 16'd1;
                    state_d  = ST_WAIT;
                end else if (in_data == OP_END) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            // First argument byte is parked; the second completes the command.
            ST_ARG: if (accept) begin
                if (!arg_sel_q) begin
                    arg_lo_d  = in_data;
                    arg_sel_d = 1'b1;
                end else if (is_apu_q) begin
                    if (arg_lo_q[7:5] == 3'd0) begin
                        reg_d   = arg_lo_q[4:0];
                        val_d   = in_data;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if ({in_data, arg_lo_q} == 16'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    tmr_load = 1'b1;
                    tmr_n    = {in_data, arg_lo_q};
                    state_d  = ST_WAIT;
                end
            end
            ST_WRITE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_FETCH;
            ST_WAIT:  if (tmr_expire) state_d = ST_FETCH;
            ST_DONE:  if (in_restart) state_d = ST_FETCH;
            ST_ERR:   if (in_restart) state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
        endcase
        wr_d   = (state_d == ST_WRITE);
        busy_d = (state_d == ST_WAIT);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_FETCH;
            arg_sel_q <= 1'b0;
            is_apu_q  <= 1'b0;
            arg_lo_q  <= 8'd0;
            reg_q     <= 5'd0;
            val_q     <= 8'd0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arg_sel_q <= arg_sel_d;
            is_apu_q  <= is_apu_d;
            arg_lo_q  <= arg_lo_d;
            reg_q     <= reg_d;
            val_q     <= val_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign out_reg  = reg_q;
    assign out_val  = val_q;
    assign out_wr   = wr_q;
    assign out_busy = busy_q;
    assign out_done = done_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_nesapu_vgm_seq.sv
// Self-checking bench for nesapu_vgm_seq: directed latency/wait/status tests
// plus random command streams compared against a stream-level model.
module tb_nesapu_vgm_seq;

    localparam int CPS = 41;

    logic       in_clk;
    logic       in_rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;
    logic       in_restart;
    logic [4:0] out_reg;
    logic [7:0] out_val;
    logic       out_wr;
    logic       out_busy;
    logic       out_done;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    logic [12:0] wrLog[$];
    int          busyCycles = 0;
    logic        prevWr = 1'b0;
    logic [7:0]  apuReg[32];

    logic [7:0]  stream[$];
    logic [12:0] expWrites[$];
    int          expWait;

    nesapu_vgm_seq #(.CLK_PER_SAMPLE(CPS)) dut (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_restart(in_restart),
        .out_reg   (out_reg),
        .out_val   (out_val),
        .out_wr    (out_wr),
        .out_busy  (out_busy),
        .out_done  (out_done),
        .out_err   (out_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Passive observer acting as a minimal nesapu register file.
    always @(negedge in_clk) begin
        if (out_wr) begin
            checkOutput("wr_single_cycle", {31'd0, prevWr}, 32'd0);
            wrLog.push_back({out_reg, out_val});
            apuReg[out_reg] = out_val;
        end
        if (out_busy) busyCycles++;
        prevWr = out_wr;
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int t = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(posedge in_clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!out_ready && t < 50000) begin
            @(posedge in_clk);
            #1;
            t++;
        end
        checkOutput("handshake_ready", {31'd0, out_ready}, 32'd1);
        @(posedge in_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        @(negedge in_clk);
        while (!out_ready && t < 50000) begin
            @(negedge in_clk);
            t++;
        end
        checkOutput("idle_ready", {31'd0, out_ready}, 32'd1);
    endtask

    task automatic measureWait(input string tag, input int expCycles);
        int n = 0;
        @(negedge in_clk);
        while (out_busy && n < 40000) begin
            n++;
            @(negedge in_clk);
        end
        checkOutput(tag, n, expCycles);
        checkOutput({tag, "_ready_after"}, {31'd0, out_ready}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr"},   {31'd0, out_wr},   32'd0);
        checkOutput({tag, "_busy"}, {31'd0, out_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, out_done}, 32'd0);
        checkOutput({tag, "_err"},  {31'd0, out_err},  32'd0);
        checkOutput({tag, "_reg"},  {27'd0, out_reg},  32'd0);
        checkOutput({tag, "_val"},  {24'd0, out_val},  32'd0);
    endtask

    // Reference: walk the byte stream command by command.
    function automatic void modelStream();
        int i = 0;
        expWrites.delete();
        expWait = 0;
        while (i < stream.size()) begin
            logic [7:0] op = stream[i];
            if (op == 8'hB4) begin
                if (stream[i+1] < 8'd32) expWrites.push_back({stream[i+1][4:0], stream[i+2]});
                i += 3;
            end else if (op == 8'h61) begin
                expWait += (int'(stream[i+1]) + 256 * int'(stream[i+2])) * CPS;
                i += 3;
            end else if (op == 8'h62) begin
                expWait += 735 * CPS;
                i += 1;
            end else if (op == 8'h63) begin
                expWait += 882 * CPS;
                i += 1;
            end else if (op >= 8'h70 && op <= 8'h7F) begin
                expWait += (int'(op) - 8'h70 + 1) * CPS;
                i += 1;
            end else begin
                i = stream.size();
            end
        end
    endfunction

    initial begin
        int mark;
        int markBusy;
        in_rst_n   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        in_restart = 1'b0;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        checkOutput("reset_ready", {31'd0, out_ready}, 32'd1);

        $display("[TB] write latency");
        applyStimulus(8'hB4, 0);
        applyStimulus(8'h15, 0);
        applyStimulus(8'h0F, 0);
        @(negedge in_clk);
        checkOutput("wr_t1", {31'd0, out_wr}, 32'd1);
        checkOutput("reg_t1", {27'd0, out_reg}, 32'h15);
        checkOutput("val_t1", {24'd0, out_val}, 32'h0F);
        @(negedge in_clk);
        checkOutput("wr_t2", {31'd0, out_wr}, 32'd0);
        checkOutput("ready_t2", {31'd0, out_ready}, 32'd0);
        @(negedge in_clk);
        checkOutput("ready_t3", {31'd0, out_ready}, 32'd1);
        checkOutput("apu_reg15", {24'd0, apuReg[5'h15]}, 32'h0F);

        $display("[TB] waits");
        applyStimulus(8'h61, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'h00, 0);
        measureWait("wait_61_16", 16 * CPS);
        applyStimulus(8'h62, 0);
        measureWait("wait_62", 735 * CPS);
        applyStimulus(8'h73, 0);
        measureWait("wait_73", 4 * CPS);
        applyStimulus(8'h61, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        measureWait("wait_61_zero", 0);

        $display("[TB] dropped write");
        mark = wrLog.size();
        applyStimulus(8'hB4, 0);
        applyStimulus(8'h20, 0);
        applyStimulus(8'h55, 0);
        applyStimulus(8'hB4, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h08, 0);
        waitIdle();
        checkOutput("drop_count", wrLog.size() - mark, 1);
        if (wrLog.size() > mark) checkOutput("drop_entry", {19'd0, wrLog[mark]}, {19'd0, 5'h03, 8'h08});

        $display("[TB] done and error");
        in_restart = 1'b1;
        applyStimulus(8'h66, 0);
        in_restart = 1'b0;
        @(negedge in_clk);
        checkOutput("done_set", {31'd0, out_done}, 32'd1);
        checkOutput("done_ready", {31'd0, out_ready}, 32'd0);
        repeat (3) @(negedge in_clk);
        checkOutput("done_hold", {31'd0, out_done}, 32'd1);
        in_restart = 1'b1;
        @(posedge in_clk);
        #1;
        in_restart = 1'b0;
        @(negedge in_clk);
        checkOutput("restart_done_clr", {31'd0, out_done}, 32'd0);
        checkOutput("restart_ready", {31'd0, out_ready}, 32'd1);
        applyStimulus(8'h50, 0);
        @(negedge in_clk);
        checkOutput("err_set", {31'd0, out_err}, 32'd1);
        checkOutput("err_ready", {31'd0, out_ready}, 32'd0);
        repeat (4) @(negedge in_clk);
        checkOutput("err_sticky", {31'd0, out_err}, 32'd1);
        in_restart = 1'b1;
        @(posedge in_clk);
        #1;
        in_restart = 1'b0;
        @(negedge in_clk);
        checkOutput("restart_err_clr", {31'd0, out_err}, 32'd0);

        $display("[TB] random streams");
        for (int it = 0; it < 3; it++) begin
            stream.delete();
            for (int c = 0; c < 10; c++) begin
                case ($urandom_range(0, 3))
                    0, 1: begin
                        stream.push_back(8'hB4);
                        if ($urandom_range(0, 3) == 0) stream.push_back(8'($urandom));
                        else stream.push_back(8'($urandom_range(0, 31)));
                        stream.push_back(8'($urandom));
                    end
                    2: begin
                        stream.push_back(8'h61);
                        stream.push_back(8'($urandom_range(0, 4)));
                        stream.push_back(8'h00);
                    end
                    default: stream.push_back(8'h70 | 8'($urandom_range(0, 15)));
                endcase
            end
            modelStream();
            mark = wrLog.size();
            markBusy = busyCycles;
            foreach (stream[k]) applyStimulus(stream[k], $urandom_range(0, 3));
            waitIdle();
            checkOutput("rnd_wr_count", wrLog.size() - mark, expWrites.size());
            foreach (expWrites[k])
                if (mark + k < wrLog.size())
                    checkOutput("rnd_wr_entry", {19'd0, wrLog[mark + k]}, {19'd0, expWrites[k]});
            checkOutput("rnd_wait_cycles", busyCycles - markBusy, expWait);
        end

        $display("[TB] reset during write");
        applyStimulus(8'hB4, 1);
        applyStimulus(8'h1F, 2);
        applyStimulus(8'hAA, 0);
        checkOutput("pre_reset_wr", {31'd0, out_wr}, 32'd1);
        #2;
        in_rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_in_write");
        @(negedge in_clk);
        in_rst_n = 1'b1;

        $display("[TB] reset during wait");
        applyStimulus(8'h61, 0);
        applyStimulus(8'hC8, 0);
        applyStimulus(8'h00, 0);
        repeat (30) @(negedge in_clk);
        checkOutput("pre_reset_busy", {31'd0, out_busy}, 32'd1);
        #2;
        in_rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_in_wait");
        @(negedge in_clk);
        checkResetOutputs("rst_held");
        in_rst_n = 1'b1;
        @(negedge in_clk);
        checkOutput("post_reset_ready", {31'd0, out_ready}, 32'd1);
        mark = wrLog.size();
        applyStimulus(8'hB4, 2);
        applyStimulus(8'h15, 1);
        applyStimulus(8'h0F, 3);
        waitIdle();
        checkOutput("post_reset_wr_count", wrLog.size() - mark, 1);
        checkOutput("post_reset_apu15", {24'd0, apuReg[5'h15]}, 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
